// File: rtl/shake256_sponge_ctrl.sv
// SHAKE256 sponge sequencer: owns the 1600-bit Keccak state, absorbs pre-padded
// rate blocks, drives an external one-round unit 24x, then squeezes N blocks.
module shake256_sponge_ctrl #(
  parameter int W      = 1600,
  parameter int RATE   = 1088,
  parameter int ROUNDS = 24,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] out_blocks,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RATE-1:0]  in_block,
  input  logic             in_last,
  output logic [W-1:0]     round_state,
  output logic [4:0]       round_idx,
  output logic             round_en,
  input  logic [W-1:0]     round_next,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RATE-1:0]  out_block,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, ABSORB, PERMUTE, SQUEEZE} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     s_q;
  logic [4:0]       rnd_q;
  logic [CNT_W-1:0] blk_q;
  logic [CNT_W-1:0] total_q;
  logic             last_q;
  logic             done_q;

  logic last_round;
  logic final_block;

  assign last_round  = (rnd_q == 5'(ROUNDS - 1));
  assign final_block = (blk_q == total_q - CNT_W'(1));

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)      state_d = ABSORB;
      ABSORB:  if (in_valid)   state_d = PERMUTE;
      PERMUTE: if (last_round) state_d = last_q ? SQUEEZE : ABSORB;
      SQUEEZE: if (out_ready)  state_d = final_block ? IDLE : PERMUTE;
      default:                 state_d = IDLE;
    endcase
  end

  // NOTE: the wide state register is reset on purpose: an aborted hash must
  // leave no residue visible on round_state or out_block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      rnd_q   <= '0;
      blk_q   <= '0;
      total_q <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == SQUEEZE) && out_ready && final_block;
      case (state_q)
        IDLE: if (start) begin
          s_q     <= '0;
          blk_q   <= '0;
          total_q <= (out_blocks == '0) ? CNT_W'(1) : out_blocks;
        end
        ABSORB: if (in_valid) begin
          s_q[RATE-1:0] <= s_q[RATE-1:0] ^ in_block;
          last_q        <= in_last;
          rnd_q         <= '0;
        end
        PERMUTE: begin
          s_q   <= round_next;
          rnd_q <= last_round ? '0 : rnd_q + 5'd1;
        end
        // last_q stays set, so the extra permutation returns here
        SQUEEZE: if (out_ready && !final_block) blk_q <= blk_q + CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    round_en  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE:    busy      = 1'b0;
      ABSORB:  in_ready  = 1'b1;
      PERMUTE: round_en  = 1'b1;
      SQUEEZE: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign round_state = s_q;
  assign round_idx   = rnd_q;
  assign out_block   = out_valid ? s_q[RATE-1:0] : '0;
  assign done        = done_q;

endmodule

// File: doc/shake256_sponge_ctrl.md
Name: shake256_sponge_ctrl

Overview:
Sequences the SHAKE256 sponge around a single-round Keccak-f[1600] datapath. The block owns the 1600-bit state register and absorbs pre-padded rate blocks. It runs 24 permutation rounds at one round per cycle through an external combinational round unit, then squeezes a host-programmed number of output blocks. It sits between the message front-end (padding already applied upstream) and the hash output interface.

Parameters:
W, 1600, state width in bits; lane (x,y) bit z is S[64*(5*y+x)+z]
RATE, 1088, rate in bits (136 bytes); absorbed/squeezed part is S[RATE-1:0]
ROUNDS, 24, Keccak-f rounds per permutation
CNT_W, 8, width of the squeeze block count

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin new hash; sampled only in IDLE
out_blocks  in  CNT_W  number of output blocks to squeeze; latched on start; 0 treated as 1
in_valid  in  1  in_block valid
in_ready  out  1  controller accepts a block this cycle
in_block  in  RATE  padded message block; byte i occupies bits [8i+7:8i]
in_last  in  1  qualifies in_block as final block
round_state  out  W  current state S driven to round unit
round_idx  out  5  round number 0..23 for iota constant
round_en  out  1  high while permuting
round_next  in  W  round unit result for round_state/round_idx, combinational
out_valid  out  1  out_block valid
out_ready  in  1  consumer accepts out_block
out_block  out  RATE  S[RATE-1:0] during SQUEEZE, else 0
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse after final output block accepted

Behaviour:
- Reset: state IDLE, S=0, round counter=0, block counter=0, last flag=0. All outputs 0 (in_ready, round_en, out_valid, busy, done, round_idx, out_block). round_state mirrors S=0. Reset mid-operation aborts immediately; no partial output.
- FSM states: IDLE, ABSORB, PERMUTE, SQUEEZE.
- IDLE: on start, S<=0, latch out_blocks (0->1), block counter<=0, go ABSORB. Outside IDLE, start is ignored.
- ABSORB: in_ready=1. On in_valid&in_ready: S[RATE-1:0]<=S[RATE-1:0]^in_block; upper W-RATE bits unchanged; last flag<=in_last; round counter<=0; go PERMUTE.
- PERMUTE: round_en=1, round_idx=round counter. Each cycle: S<=round_next, counter++. In the cycle with counter==ROUNDS-1, the counter clears and the FSM goes to SQUEEZE if the last flag is set, else to ABSORB. Exactly 24 cycles per permutation.
- SQUEEZE: out_valid=1, out_block=S[RATE-1:0], held stable until out_ready. On out_valid&out_ready:
  - if block counter==latched count-1: go IDLE; done=1 for the next cycle.
  - else: block counter++, go PERMUTE (last flag stays set, so return is to SQUEEZE).
- Latency: block accepted at edge k -> round_en high for cycles k+1..k+24 -> out_valid high from cycle k+25 (final block), or in_ready high at k+25 (non-final).
- Back-pressure: out_ready low holds SQUEEZE indefinitely with out_block unchanged. in_valid low holds ABSORB indefinitely.
- done and start in the same cycle: done is already in IDLE, so start is accepted.
- in_ready is never high while busy outside ABSORB. No input is buffered.

Test Plan:
- Reset then idle: assert rst_n low mid-PERMUTE -> busy=0, round_en=0, S=0 immediately; outputs stay 0 with no start.
- Empty message: start, out_blocks=1, single in_block with byte0=0x1F, byte135=0x80, in_last=1 -> out_valid at accept+25. out_block bytes 0..31 = 46b9dd2b0ba88d13233b3feb743eeb243fcd52ea62b81b82b50c27646ed5762f; done pulses once.
- Two-block message: 136 bytes of 0xA3, padded second block with in_last=1 -> in_ready reasserts exactly 25 cycles after first accept; output matches the reference SHAKE256 model.
- Multi-block squeeze: out_blocks=3 with the empty message -> three out_valid handshakes, each separated by 24 round_en cycles. Concatenation equals the first 408 bytes of the SHAKE256("") model.
- Back-pressure: hold out_ready=0 for 50 cycles -> out_block stable, round_en=0 throughout. Also start pulsed mid-PERMUTE -> ignored, round_idx continues 0..23.
- out_blocks=0 -> exactly one output block, then done.
